// File: rtl/axi4_lite_fanin_pkg.sv
// Shared types for the two-port AXI4-Lite write fan-in stage.
package axi4_lite_fanin_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b01,
    StIssue = 2'b10
  } fanin_state_e;

  typedef logic tag_t;

  function automatic logic [1:0] tag_onehot(tag_t t);
    return t ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi4_lite_tag_fifo.sv
// First-word fall-through FIFO holding the originating port of each issued write.
module axi4_lite_tag_fifo #(
  parameter int unsigned W = 1,
  parameter int unsigned D = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 push,
  input  logic [W-1:0]         wdata,
  input  logic                 pop,
  output logic [W-1:0]         rdata,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);

  localparam int unsigned PW = $clog2(D);
  localparam logic [PW:0] DepthCnt = (PW + 1)'(D);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge aclk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_fanin_wr.sv
// Merges two AXI4-Lite write ports into one, one write in flight, B routed back by tag.
module axi4_lite_fanin_wr
  import axi4_lite_fanin_pkg::*;
#(
  parameter int unsigned A = 32,
  parameter int unsigned N = 4,
  parameter int unsigned D = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  // upstream write ports 0 and 1
  input  logic [1:0]             s_awvalid,
  output logic [1:0]             s_awready,
  input  logic [1:0][A-1:0]      s_awaddr,
  input  logic [1:0][2:0]        s_awprot,
  input  logic [1:0]             s_wvalid,
  output logic [1:0]             s_wready,
  input  logic [1:0][8*N-1:0]    s_wdata,
  input  logic [1:0][N-1:0]      s_wstrb,
  output logic [1:0]             s_bvalid,
  input  logic [1:0]             s_bready,
  output logic [1:0][1:0]        s_bresp,
  output logic [1:0]             s_arready,
  output logic [1:0]             s_rvalid,
  // merged downstream write port
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [A-1:0]           m_awaddr,
  output logic [2:0]             m_awprot,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  output logic [8*N-1:0]         m_wdata,
  output logic [N-1:0]           m_wstrb,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  input  logic [1:0]             m_bresp,
  output logic                   m_arvalid,
  output logic                   m_rready,
  output logic [$clog2(D):0]     wr_outstanding
);

  fanin_state_e   state_q;
  logic           aw_done_q, w_done_q;
  tag_t           last_grant_q;
  logic           m_awvalid_q, m_wvalid_q;
  logic [A-1:0]   awaddr_q;
  logic [2:0]     awprot_q;
  logic [8*N-1:0] wdata_q;
  logic [N-1:0]   wstrb_q;

  logic [1:0] cand;
  logic       grant_en;
  tag_t       grant_tag;
  logic [1:0] grant_mask;
  logic       aw_hs, w_hs, aw_fin, w_fin;
  logic       fifo_full, fifo_empty, fifo_pop;
  tag_t       head_tag;
  logic [1:0] b_mask;

  assign s_arready = 2'b00;
  assign s_rvalid  = 2'b00;
  assign m_arvalid = 1'b0;
  assign m_rready  = 1'b0;

  // Arbitration: only ports with both AW and W valid compete.
  assign cand       = s_awvalid & s_wvalid;
  assign grant_en   = aresetn & (state_q == StIdle) & ~fifo_full & (|cand);
  assign grant_tag  = (cand == 2'b11) ? ~last_grant_q : tag_t'(cand[1]);
  assign grant_mask = grant_en ? tag_onehot(grant_tag) : 2'b00;
  assign s_awready  = grant_mask;
  assign s_wready   = grant_mask;

  assign m_awvalid = m_awvalid_q;
  assign m_wvalid  = m_wvalid_q;
  assign m_awaddr  = awaddr_q;
  assign m_awprot  = awprot_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;

  assign aw_hs  = m_awvalid_q & m_awready;
  assign w_hs   = m_wvalid_q & m_wready;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      last_grant_q <= 1'b1;
      m_awvalid_q  <= 1'b0;
      m_wvalid_q   <= 1'b0;
      awaddr_q     <= '0;
      awprot_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_en) begin
            awaddr_q     <= s_awaddr[grant_tag];
            awprot_q     <= s_awprot[grant_tag];
            wdata_q      <= s_wdata[grant_tag];
            wstrb_q      <= s_wstrb[grant_tag];
            m_awvalid_q  <= 1'b1;
            m_wvalid_q   <= 1'b1;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            last_grant_q <= grant_tag;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (aw_hs) begin
            m_awvalid_q <= 1'b0;
            aw_done_q   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid_q <= 1'b0;
            w_done_q   <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Responses follow issue order; an empty FIFO blocks any stray B.
  assign b_mask   = (aresetn & ~fifo_empty) ? tag_onehot(head_tag) : 2'b00;
  assign s_bvalid = b_mask & {2{m_bvalid}};
  assign s_bresp  = {2{m_bresp}};
  assign m_bready = |(b_mask & s_bready);
  assign fifo_pop = m_bvalid & m_bready;

  axi4_lite_tag_fifo #(
    .W (1),
    .D (D)
  ) u_tag_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (grant_en),
    .wdata   (grant_tag),
    .pop     (fifo_pop),
    .rdata   (head_tag),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (wr_outstanding)
  );

endmodule

// File: tb/tb_axi4_lite_fanin_wr.sv
// Scenario tasks plus a randomized run against a transaction-level model.
module tb_axi4_lite_fanin_wr;

  localparam int unsigned A  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D) + 1;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  logic [1:0]          s_awvalid, s_awready, s_wvalid, s_wready;
  logic [1:0]          s_bvalid, s_bready, s_arready, s_rvalid;
  logic [1:0][A-1:0]   s_awaddr;
  logic [1:0][2:0]     s_awprot;
  logic [1:0][8*N-1:0] s_wdata;
  logic [1:0][N-1:0]   s_wstrb;
  logic [1:0][1:0]     s_bresp;
  logic                m_awvalid, m_awready, m_wvalid, m_wready;
  logic                m_bvalid, m_bready, m_arvalid, m_rready;
  logic [A-1:0]        m_awaddr;
  logic [2:0]          m_awprot;
  logic [8*N-1:0]      m_wdata;
  logic [N-1:0]        m_wstrb;
  logic [1:0]          m_bresp;
  logic [CW-1:0]       wr_outstanding;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axi4_lite_fanin_wr #(.A(A), .N(N), .D(D)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_awvalid      (s_awvalid),
    .s_awready      (s_awready),
    .s_awaddr       (s_awaddr),
    .s_awprot       (s_awprot),
    .s_wvalid       (s_wvalid),
    .s_wready       (s_wready),
    .s_wdata        (s_wdata),
    .s_wstrb        (s_wstrb),
    .s_bvalid       (s_bvalid),
    .s_bready       (s_bready),
    .s_bresp        (s_bresp),
    .s_arready      (s_arready),
    .s_rvalid       (s_rvalid),
    .m_awvalid      (m_awvalid),
    .m_awready      (m_awready),
    .m_awaddr       (m_awaddr),
    .m_awprot       (m_awprot),
    .m_wvalid       (m_wvalid),
    .m_wready       (m_wready),
    .m_wdata        (m_wdata),
    .m_wstrb        (m_wstrb),
    .m_bvalid       (m_bvalid),
    .m_bready       (m_bready),
    .m_bresp        (m_bresp),
    .m_arvalid      (m_arvalid),
    .m_rready       (m_rready),
    .wr_outstanding (wr_outstanding)
  );

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    s_awaddr = '0; s_awprot = '0; s_wdata = '0; s_wstrb = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 1'b0;
    next_cycle();
    next_cycle();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
    m_bvalid = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    s_awaddr[0] = 32'hDEAD_BEEF; s_wdata[0] = 32'h1234_5678;
    next_cycle();
    next_cycle();
    to_sample();
    n_cmp++;
    if ({s_awready, s_wready} !== 4'b0) begin
      n_err++; $display("FAIL reset_ready: got %b expected 0000", {s_awready, s_wready});
    end
    n_cmp++;
    if ({s_bvalid, m_awvalid, m_wvalid, m_bready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b expected 00000", {s_bvalid, m_awvalid, m_wvalid, m_bready});
    end
    n_cmp++;
    if ({m_awaddr, m_awprot, m_wdata, m_wstrb} !== '0) begin
      n_err++; $display("FAIL reset_payload: got %h %h expected 0", m_awaddr, m_wdata);
    end
    n_cmp++;
    if (wr_outstanding !== '0) begin
      n_err++; $display("FAIL reset_count: got %0d expected 0", wr_outstanding);
    end
    n_cmp++;
    if ({s_arready, s_rvalid, m_arvalid, m_rready} !== 6'b0) begin
      n_err++;
      $display("FAIL read_tied: got %b expected 000000", {s_arready, s_rvalid, m_arvalid, m_rready});
    end
    next_cycle();
    idle_inputs();
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    s_awvalid[0] = 1'b1; s_awaddr[0] = 32'h10; s_awprot[0] = 3'd2;
    s_wvalid[0] = 1'b1; s_wdata[0] = 32'hA5A5_A5A5; s_wstrb[0] = 4'hF;
    to_sample();
    n_cmp++;
    if ({s_awready, s_wready} !== 4'b0101) begin
      n_err++; $display("FAIL single_grant: got %b expected 0101", {s_awready, s_wready});
    end
    n_cmp++;
    if (m_awvalid !== 1'b0) begin
      n_err++; $display("FAIL single_latency: m_awvalid got %b expected 0", m_awvalid);
    end
    next_cycle();
    s_awvalid = '0; s_wvalid = '0; m_awready = 1'b1; m_wready = 1'b1;
    to_sample();
    n_cmp++;
    if ({m_awvalid, m_wvalid, m_awaddr, m_awprot, m_wdata, m_wstrb} !==
        {2'b11, 32'h10, 3'd2, 32'hA5A5_A5A5, 4'hF}) begin
      n_err++; $display("FAIL single_issue: got v=%b a=%h d=%h expected v=11 a=10 d=a5a5a5a5",
                        {m_awvalid, m_wvalid}, m_awaddr, m_wdata);
    end
    next_cycle();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 2'b11;
    to_sample();
    n_cmp++;
    if ({m_awvalid, s_bvalid, m_bready, s_bresp[0]} !== {1'b0, 2'b01, 1'b1, 2'b00}) begin
      n_err++; $display("FAIL single_b: got awv=%b bvalid=%b bready=%b expected awv=0 bvalid=01 bready=1",
                        m_awvalid, s_bvalid, m_bready);
    end
    next_cycle();
    m_bvalid = 1'b0; s_bready = '0;
    to_sample();
    n_cmp++;
    if (wr_outstanding !== '0) begin
      n_err++; $display("FAIL single_drain: count got %0d expected 0", wr_outstanding);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    int lg;
    int exp_g;
    int exp_b[$];
    logic [1:0] got_b[$];
    do_reset();
    lg = 1;
    m_bvalid = 1'b1; s_bready = 2'b11; m_bresp = 2'b00;
    for (int r = 0; r < 5; r++) begin
      s_awvalid = 2'b11; s_wvalid = 2'b11;
      s_awaddr[0] = 32'h100 + r; s_awaddr[1] = 32'h200 + r;
      to_sample();
      if (m_bvalid && m_bready) got_b.push_back(s_bvalid);
      exp_g = (lg == 0) ? 1 : 0;
      n_cmp++;
      if (s_awready !== ((exp_g == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL contention_grant[%0d]: got %b expected port %0d", r, s_awready, exp_g);
      end
      exp_b.push_back(exp_g);
      lg = exp_g;
      next_cycle();
      s_awvalid[exp_g] = 1'b0; s_wvalid[exp_g] = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
      to_sample();
      if (m_bvalid && m_bready) got_b.push_back(s_bvalid);
      n_cmp++;
      if (s_awready !== 2'b00 || m_awaddr !== ((exp_g == 0 ? 32'h100 : 32'h200) + r)) begin
        n_err++; $display("FAIL contention_issue[%0d]: ready=%b addr=%h expected ready=00 port %0d", r,
                          s_awready, m_awaddr, exp_g);
      end
      next_cycle();
      m_awready = 1'b0; m_wready = 1'b0;
    end
    s_awvalid = '0; s_wvalid = '0;
    for (int c = 0; c < 8; c++) begin
      to_sample();
      if (m_bvalid && m_bready) got_b.push_back(s_bvalid);
      next_cycle();
    end
    m_bvalid = 1'b0;
    n_cmp++;
    if (got_b.size() != 5) begin
      n_err++; $display("FAIL contention_b_count: got %0d expected 5", got_b.size());
    end
    for (int i = 0; i < 5 && i < got_b.size(); i++) begin
      n_cmp++;
      if (got_b[i] !== ((exp_b[i] == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL contention_b_order[%0d]: got %b expected port %0d", i, got_b[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_split();
    do_reset();
    s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1; s_awaddr[1] = 32'h44; s_wdata[1] = 32'h1234_5678;
    to_sample();
    n_cmp++;
    if (s_awready !== 2'b10) begin
      n_err++; $display("FAIL split_grant: got %b expected 10", s_awready);
    end
    next_cycle();
    s_awvalid = 2'b01; s_wvalid = 2'b01; s_awaddr[0] = 32'h88;
    m_awready = 1'b0; m_wready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      to_sample();
      n_cmp++;
      if ({m_awvalid, m_wvalid, s_awready} !== {1'b1, (c == 0), 2'b00} || m_awaddr !== 32'h44) begin
        n_err++; $display("FAIL split_hold[%0d]: got awv=%b wv=%b rdy=%b addr=%h expected 1 %0d 00 44", c,
                          m_awvalid, m_wvalid, s_awready, m_awaddr, (c == 0));
      end
      next_cycle();
    end
    m_awready = 1'b1;
    to_sample();
    n_cmp++;
    if ({m_awvalid, s_awready} !== 3'b100) begin
      n_err++; $display("FAIL split_aw_cycle: got awv=%b rdy=%b expected 1 00", m_awvalid, s_awready);
    end
    next_cycle();
    m_awready = 1'b0;
    to_sample();
    n_cmp++;
    if ({m_awvalid, s_awready} !== 3'b001) begin
      n_err++; $display("FAIL split_idle: got awv=%b rdy=%b expected 0 01", m_awvalid, s_awready);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_outstanding();
    int grants;
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
    grants = 0;
    for (int c = 0; c < 16; c++) begin
      to_sample();
      if (s_awready != 2'b00) grants++;
      next_cycle();
    end
    n_cmp++;
    if (grants != 4 || wr_outstanding !== 3'd4) begin
      n_err++; $display("FAIL limit_grants: got %0d grants count %0d expected 4 and 4", grants, wr_outstanding);
    end
    m_bvalid = 1'b1;
    to_sample();
    n_cmp++;
    if ({m_bready, s_bvalid, s_awready} !== 5'b10100) begin
      n_err++; $display("FAIL limit_pop: got bready=%b bvalid=%b rdy=%b expected 1 01 00",
                        m_bready, s_bvalid, s_awready);
    end
    next_cycle();
    m_bvalid = 1'b0;
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      to_sample();
      if (s_awready != 2'b00) grants++;
      next_cycle();
    end
    n_cmp++;
    if (grants != 1) begin
      n_err++; $display("FAIL limit_one_more: got %0d grants expected 1", grants);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; s_awvalid = 2'b11; s_wvalid = 2'b11;
    to_sample();
    next_cycle();
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    to_sample();
    next_cycle();
    to_sample();
    next_cycle();
    s_awvalid = 2'b00; s_wvalid = 2'b00;
    to_sample();
    n_cmp++;
    if (wr_outstanding !== 3'd2) begin
      n_err++; $display("FAIL simul_setup: count got %0d expected 2", wr_outstanding);
    end
    next_cycle();
    s_awvalid = 2'b01; s_wvalid = 2'b01; m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 2'b11;
    to_sample();
    n_cmp++;
    if ({s_awready, m_bready, s_bvalid} !== 5'b01101) begin
      n_err++; $display("FAIL simul_push_pop: got rdy=%b bready=%b bvalid=%b expected 01 1 01",
                        s_awready, m_bready, s_bvalid);
    end
    next_cycle();
    s_awvalid = 2'b00; s_wvalid = 2'b00; m_bresp = 2'b10;
    to_sample();
    n_cmp++;
    if (wr_outstanding !== 3'd2) begin
      n_err++; $display("FAIL simul_count: got %0d expected 2", wr_outstanding);
    end
    n_cmp++;
    if ({s_bvalid, s_bresp[1]} !== 4'b1010) begin
      n_err++; $display("FAIL simul_slverr: got bvalid=%b bresp=%b expected 10 10", s_bvalid, s_bresp[1]);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; s_awvalid = 2'b11; s_wvalid = 2'b11;
    to_sample();
    next_cycle();
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    to_sample();
    next_cycle();
    to_sample();
    next_cycle();
    s_awvalid = 2'b00; s_wvalid = 2'b00; m_awready = 1'b0; m_wready = 1'b0;
    to_sample();
    n_cmp++;
    if (wr_outstanding !== 3'd2 || m_awvalid !== 1'b1) begin
      n_err++; $display("FAIL midrst_setup: count=%0d awv=%b expected 2 1", wr_outstanding, m_awvalid);
    end
    next_cycle();
    aresetn = 1'b0; m_bvalid = 1'b1; s_bready = 2'b11;
    next_cycle();
    aresetn = 1'b1; s_awvalid = 2'b11; s_wvalid = 2'b11;
    to_sample();
    n_cmp++;
    if ({wr_outstanding, m_awvalid, m_bready} !== {3'd0, 2'b00}) begin
      n_err++; $display("FAIL midrst_clear: count=%0d awv=%b bready=%b expected 0 0 0",
                        wr_outstanding, m_awvalid, m_bready);
    end
    n_cmp++;
    if (s_awready !== 2'b01) begin
      n_err++; $display("FAIL midrst_grant: got %b expected 01", s_awready);
    end
    next_cycle();
    idle_inputs();
  endtask

  // Model: one write in flight, tags in a queue, round-robin on ties.
  task automatic test_random();
    logic [1:0]     awv, wv, cand, exp_mask, exp_b;
    logic [A-1:0]   addr [2];
    logic [8*N-1:0] data [2];
    logic [N-1:0]   strb [2];
    int             tq[$];
    int             lg, g;
    logic           busy, aw_pend, w_pend, exp_bready;
    logic [A-1:0]   cur_addr;
    logic [8*N-1:0] cur_data;
    do_reset();
    awv = '0; wv = '0; lg = 1; busy = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
    cur_addr = '0; cur_data = '0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; data[p] = '0; strb[p] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!awv[p] && $urandom_range(0, 2) == 0) begin awv[p] = 1'b1; addr[p] = $urandom; end
        if (!wv[p] && $urandom_range(0, 2) == 0) begin
          wv[p] = 1'b1; data[p] = $urandom; strb[p] = 4'($urandom_range(0, 15));
        end
        s_awaddr[p] = addr[p]; s_wdata[p] = data[p]; s_wstrb[p] = strb[p];
      end
      s_awvalid = awv; s_wvalid = wv;
      m_awready = 1'($urandom_range(0, 1)); m_wready = 1'($urandom_range(0, 1));
      m_bvalid = ($urandom_range(0, 2) == 0); m_bresp = 2'($urandom_range(0, 3));
      s_bready = 2'($urandom_range(0, 3));
      to_sample();
      cand = awv & wv;
      g = -1;
      if (!busy && tq.size() < int'(D) && cand != 2'b00)
        g = (cand == 2'b11) ? ((lg == 0) ? 1 : 0) : (cand[1] ? 1 : 0);
      exp_mask = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      n_cmp++;
      if (s_awready !== exp_mask || s_wready !== exp_mask) begin
        n_err++; $display("FAIL rand_grant@%0d: got aw=%b w=%b expected %b", cyc, s_awready, s_wready, exp_mask);
      end
      n_cmp++;
      if (m_awvalid !== aw_pend || m_wvalid !== w_pend ||
          (aw_pend && m_awaddr !== cur_addr) || (w_pend && m_wdata !== cur_data)) begin
        n_err++; $display("FAIL rand_issue@%0d: got v=%b%b a=%h d=%h expected v=%b%b a=%h d=%h", cyc,
                          m_awvalid, m_wvalid, m_awaddr, m_wdata, aw_pend, w_pend, cur_addr, cur_data);
      end
      exp_b = 2'b00; exp_bready = 1'b0;
      if (tq.size() > 0) begin
        exp_b      = m_bvalid ? ((tq[0] == 0) ? 2'b01 : 2'b10) : 2'b00;
        exp_bready = s_bready[tq[0]];
      end
      n_cmp++;
      if (s_bvalid !== exp_b || m_bready !== exp_bready ||
          (exp_b != 2'b00 && s_bresp[tq[0]] !== m_bresp)) begin
        n_err++; $display("FAIL rand_b@%0d: got bvalid=%b bready=%b expected %b %b", cyc,
                          s_bvalid, m_bready, exp_b, exp_bready);
      end
      if (busy) begin
        if (m_awready) aw_pend = 1'b0;
        if (m_wready) w_pend = 1'b0;
        if (!aw_pend && !w_pend) busy = 1'b0;
      end
      if (tq.size() > 0 && m_bvalid && exp_bready) void'(tq.pop_front());
      if (g >= 0) begin
        tq.push_back(g); lg = g; busy = 1'b1; aw_pend = 1'b1; w_pend = 1'b1;
        cur_addr = addr[g]; cur_data = data[g];
        awv[g] = 1'b0; wv[g] = 1'b0;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_split();
    test_outstanding();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_lite_fanin_wr.md
AXI4_LITE_FANIN_WR -- requirements
Module: axi4_lite_fanin_wr

Interface
REQ-001 Parameter A, default 32: address width in bits.
REQ-002 Parameter N, default 4: data bus width in bytes.
REQ-003 Parameter D, default 4: maximum outstanding writes; must be a power of 2 and at least 2.
REQ-004 aclk  input  1  clock; all logic SHALL be on the rising edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 axi4_s[2]  axi4_lite_if (slave side)  A/N  write upstream ports 0 and 1.
REQ-007 axi4_m  axi4_lite_if (master side)  A/N  single merged write port; feeds the fanout write stage.
REQ-008 Read channels are not handled:
- s[j].arready=0, s[j].rvalid=0.
- m.arvalid=0, m.rready=0.

Function
REQ-009 States: IDLE, ISSUE. The block SHALL hold at most one write in flight in the issue stage.
REQ-010 A port j is a candidate when s[j].awvalid & s[j].wvalid are both 1; a port with only one of them valid is never granted.
REQ-011 In IDLE with the tag FIFO not full:
- One candidate: that port is granted.
- Two candidates: the port not granted last time wins (round-robin).
REQ-012 Grant cycle actions:
- Pulse s[j].awready=1 and s[j].wready=1 for one cycle.
- Register awaddr, awprot, wdata and wstrb.
- Push j into the tag FIFO.
- Update last_grant=j.
- Go to ISSUE.
REQ-013 awready and wready of a non-granted port SHALL be 0 every cycle.
REQ-014 ISSUE:
- m.awvalid and m.wvalid SHALL be 1 starting the cycle after the grant (latency 1).
- Each valid drops independently after its own handshake; aw_done and w_done record the completed handshakes.
- Return to IDLE in the cycle in which the second handshake completes.
- The registered payload SHALL remain stable while its valid is high.
REQ-015 No new grant SHALL occur in ISSUE, or in the IDLE cycle where count==D (FIFO full).
REQ-016 B routing:
- Let t = tag at the FIFO head.
- s[t].bvalid = m.bvalid & ~empty; s[t].bresp = m.bresp.
- m.bready = s[t].bready & ~empty.
- The other port's bvalid SHALL be 0.
REQ-017 Pop the tag FIFO on an m.bvalid & m.bready handshake. With the FIFO empty, m.bready=0 (an unexpected response stalls).
REQ-018 Occupancy count is $clog2(D)+1 bits:
- Push only: +1.
- Pop only: -1.
- Push and pop in the same cycle: unchanged.
- The FIFO SHALL never overflow or underflow.
REQ-019 Responses SHALL return to their originating ports in issue order, including when consecutive writes alternate between ports.

Reset
REQ-020 While aresetn=0, all of the following SHALL hold:
- state=IDLE, aw_done=0, w_done=0.
- count=0, FIFO pointers=0.
- last_grant=1, so port 0 wins the first tie.
REQ-021 Output values during reset:
- Every valid and ready output SHALL be 0.
- The registered payload SHALL be 0.
REQ-022 Reset asserted mid-transaction SHALL discard the in-flight write and all pending tags; the block SHALL be in IDLE on the first cycle after release.

Structure
REQ-023 Package axi4_lite_fanin_pkg SHALL hold:
- The state enum (one-hot: IDLE=2'b01, ISSUE=2'b10).
- Port-index typedef tag_t (1 bit).
REQ-024 The tag FIFO SHALL be the sub-module axi4_lite_tag_fifo:
- Parameters W (data width) and D (depth).
- Synchronous, first-word fall-through.
- Outputs: full, empty, count.
REQ-025 Expected RTL size is 150-300 lines, excluding the sub-module.

Verification
REQ-026 Single write, no contention:
- Stimulus: port 0 writes awaddr=0x10, wdata=0xA5A5A5A5.
- Grant cycle T; m.awvalid/m.wvalid=1 at T+1.
- m.bresp=OKAY is returned on s[0] only.
REQ-027 Contention after reset:
- Stimulus: both ports valid in the same cycle, five times in a row.
- Grants SHALL be 0,1,0,1,0.
- B responses SHALL arrive at ports 0,1,0,1,0 in that order.
REQ-028 Split handshakes:
- Stimulus: m.awready held at 0 for 3 cycles while m.wready=1.
- m.wvalid drops after 1 cycle; m.awvalid stays high with a stable address.
- The block returns to IDLE on the awready cycle.
REQ-029 Outstanding limit:
- Stimulus: m.bvalid held at 0 while 6 writes are issued with D=4.
- Exactly 4 grants occur; awready stays 0 until the first B handshake.
- One B handshake allows exactly one more grant.
REQ-030 Simultaneous events:
- Stimulus: a grant push and a B pop in the same cycle at count=2.
- count stays 2.
- Next stimulus: bresp=SLVERR on tag 1; s[1] sees SLVERR.
REQ-031 Reset mid-operation:
- Stimulus: aresetn=0 in ISSUE with 2 tags pending.
- After release: count=0; m.awvalid=0, m.bready=0.
- The next grant goes to port 0.
